// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - parametrised Gray-code up/down counter with step prescaler and load
//
// Purpose:
//   Counts in Gray code, one step every DIV enabled clock cycles, up or down,
//   with a synchronous Gray-value load. All outputs come straight from flops.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         count enable (prescaler and counter advance only while high)
//   up_dn      1 = count up, 0 = count down, sampled at each step
//   load       synchronous load strobe (beats a coincident step)
//   load_gray  Gray value loaded when load=1
//   gray_out   registered Gray count
//   bin_out    registered binary equivalent of gray_out
//   step       one-cycle pulse: gray_out changed by a count step
//   wrap       one-cycle pulse: that step wrapped around

module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             step,
  output logic             wrap
);

  // Prescaler needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // With DIV=1 presc never leaves 0, so this reduces to tick = en.
  assign tick = en && (presc == PW'(DIV - 1));

  always_comb begin
    bin_next  = bin_out;
    wrap_next = 1'b0;
    if (up_dn) begin
      bin_next  = bin_out + WIDTH'(1);
      wrap_next = &bin_out;
    end else begin
      bin_next  = bin_out - WIDTH'(1);
      wrap_next = ~|bin_out;
    end
  end

  // Prescaler: cleared by load or tick, held (not cleared) while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load || tick) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PW'(1);
    end
  end

  // bin_out is the binary state itself, so it always tracks gray_out on the
  // same edge with no decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      bin_out  <= gray2bin(load_gray);
      gray_out <= load_gray;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else if (tick) begin
      bin_out  <= bin_next;
      gray_out <= bin2gray(bin_next);
      step     <= 1'b1;
      wrap     <= wrap_next;
    end else begin
      step     <= 1'b0;
      wrap     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed self-checking bench for gray_updown_counter

module tb_gray_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance A: WIDTH=4, DIV=2
  logic       a_rst_n = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [3:0] a_lg = 4'h0;
  logic [3:0] a_gray, a_bin;
  logic       a_step, a_wrap;

  // Instance B: WIDTH=4, DIV=3
  logic       b_rst_n = 1'b0, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [3:0] b_lg = 4'h0;
  logic [3:0] b_gray, b_bin;
  logic       b_step, b_wrap;

  // Instance C: WIDTH=8, DIV=1
  logic       c_rst_n = 1'b0, c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
  logic [7:0] c_lg = 8'h00;
  logic [7:0] c_gray, c_bin;
  logic       c_step, c_wrap;

  gray_updown_counter #(.WIDTH(4), .DIV(2)) u_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_gray(a_lg), .gray_out(a_gray), .bin_out(a_bin), .step(a_step), .wrap(a_wrap)
  );

  gray_updown_counter #(.WIDTH(4), .DIV(3)) u_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_gray(b_lg), .gray_out(b_gray), .bin_out(b_bin), .step(b_step), .wrap(b_wrap)
  );

  gray_updown_counter #(.WIDTH(8), .DIV(1)) u_c (
    .clk(clk), .rst_n(c_rst_n), .en(c_en), .up_dn(c_up), .load(c_load),
    .load_gray(c_lg), .gray_out(c_gray), .bin_out(c_bin), .step(c_step), .wrap(c_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] gseq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] prev4;
  logic [7:0] prev8, exp_b;
  int         nsteps, nwraps;

  initial begin
    // ---- reset state on all instances
    cyc(1);
    chk("a_rst_gray", 32'(a_gray), 32'h0);
    chk("a_rst_bin",  32'(a_bin),  32'h0);
    chk("a_rst_step", 32'(a_step), 32'h0);
    chk("a_rst_wrap", 32'(a_wrap), 32'h0);
    chk("b_rst_gray", 32'(b_gray), 32'h0);
    chk("c_rst_gray", 32'(c_gray), 32'h0);

    // ---- 1: W4 D2 count up full cycle
    a_rst_n = 1'b1; a_en = 1'b1; a_up = 1'b1;
    prev4 = 4'h0; nsteps = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      chk("t1_idle_step", 32'(a_step), 32'h0);
      chk("t1_idle_gray", 32'(a_gray), 32'(prev4));
      cyc(1);
      if (a_step) nsteps++;
      chk("t1_step",  32'(a_step), 32'h1);
      chk("t1_gray",  32'(a_gray), 32'(gseq[i]));
      chk("t1_bin",   32'(a_bin),  32'((i + 1) % 16));
      chk("t1_wrap",  32'(a_wrap), (i == 15) ? 32'h1 : 32'h0);
      chk("t1_onebit", 32'($countones(a_gray ^ prev4)), 32'h1);
      prev4 = a_gray;
    end
    chk("t1_nsteps", 32'(nsteps), 32'd16);

    // ---- 2: W4 D2 count down from reset
    a_rst_n = 1'b0; a_up = 1'b0;
    cyc(1);
    a_rst_n = 1'b1;
    cyc(2);
    chk("t2_gray0", 32'(a_gray), 32'h8);
    chk("t2_bin0",  32'(a_bin),  32'hF);
    chk("t2_wrap0", 32'(a_wrap), 32'h1);
    cyc(2);
    chk("t2_gray1", 32'(a_gray), 32'h9);
    chk("t2_wrap1", 32'(a_wrap), 32'h0);
    cyc(2);
    chk("t2_gray2", 32'(a_gray), 32'hB);
    chk("t2_wrap2", 32'(a_wrap), 32'h0);

    // ---- 4: load collides with tick (bin D, presc 0 here)
    a_up = 1'b1;
    cyc(1);
    chk("t4_pre_step", 32'(a_step), 32'h0);
    a_load = 1'b1; a_lg = 4'hE;
    cyc(1);
    a_load = 1'b0;
    chk("t4_ld_gray", 32'(a_gray), 32'hE);
    chk("t4_ld_bin",  32'(a_bin),  32'hB);
    chk("t4_ld_step", 32'(a_step), 32'h0);
    cyc(2);
    chk("t4_g1", 32'(a_gray), 32'hA);
    chk("t4_b1", 32'(a_bin),  32'hC);
    cyc(2);
    chk("t4_g2", 32'(a_gray), 32'hB);
    chk("t4_b2", 32'(a_bin),  32'hD);

    // ---- 6: async reset at gray=6
    a_rst_n = 1'b0;
    cyc(1);
    a_rst_n = 1'b1;
    cyc(8);
    chk("t6_at6", 32'(a_gray), 32'h6);
    #2 a_rst_n = 1'b0;
    #1;
    chk("t6_async_gray", 32'(a_gray), 32'h0);
    chk("t6_async_bin",  32'(a_bin),  32'h0);
    chk("t6_async_step", 32'(a_step), 32'h0);
    @(negedge clk);
    a_rst_n = 1'b1;
    cyc(1);
    chk("t6_rel1_step", 32'(a_step), 32'h0);
    chk("t6_rel1_gray", 32'(a_gray), 32'h0);
    cyc(1);
    chk("t6_rel2_step", 32'(a_step), 32'h1);
    chk("t6_rel2_gray", 32'(a_gray), 32'h1);

    // ---- 3: W4 D3 prescaler held while en low
    b_rst_n = 1'b1; b_en = 1'b1;
    cyc(2);
    chk("t3_pre_step", 32'(b_step), 32'h0);
    b_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t3_idle_step", 32'(b_step), 32'h0);
      chk("t3_idle_gray", 32'(b_gray), 32'h0);
    end
    b_en = 1'b1;
    cyc(1);
    chk("t3_step", 32'(b_step), 32'h1);
    chk("t3_gray", 32'(b_gray), 32'h1);

    // ---- 5: W8 D1 300 up then 300 down
    c_rst_n = 1'b1; c_en = 1'b1; c_up = 1'b1;
    exp_b = 8'h00; prev8 = 8'h00; nwraps = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      exp_b = exp_b + 8'd1;
      if (c_wrap) nwraps++;
      chk("t5u_bin",  32'(c_bin), 32'(exp_b));
      chk("t5u_gray", 32'(c_gray), 32'(exp_b ^ (exp_b >> 1)));
      chk("t5u_inv",  32'(c_gray), 32'(c_bin ^ (c_bin >> 1)));
      chk("t5u_onebit", 32'($countones(c_gray ^ prev8)), 32'h1);
      prev8 = c_gray;
    end
    chk("t5u_wraps", 32'(nwraps), 32'd1);
    c_up = 1'b0; nwraps = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      exp_b = exp_b - 8'd1;
      if (c_wrap) nwraps++;
      chk("t5d_bin",  32'(c_bin), 32'(exp_b));
      chk("t5d_inv",  32'(c_gray), 32'(c_bin ^ (c_bin >> 1)));
      chk("t5d_onebit", 32'($countones(c_gray ^ prev8)), 32'h1);
      prev8 = c_gray;
    end
    chk("t5d_wraps", 32'(nwraps), 32'd1);
    chk("t5_final_bin",  32'(c_bin),  32'h0);
    chk("t5_final_gray", 32'(c_gray), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised Gray-code counter with programmable step prescaler, up/down direction, count enable and synchronous Gray-value load. It is the general-purpose successor to the fixed 4-bit, divide-by-2 Gray counter. It is used for FIFO pointers, position encoders and low-switching-activity timebases. All outputs are registered and glitch-free; nothing is decoded combinationally after the flops.

Parameters:
WIDTH  4  counter width in bits (>=2)
DIV    2  clock cycles per count step while enabled (>=1; DIV=1 steps every enabled cycle)

Ports:
clk        input   1      clock, rising edge
rst_n      input   1      asynchronous active-low reset
en         input   1      count enable; prescaler and counter advance only while high
up_dn      input   1      1 = count up, 0 = count down; sampled at each step
load       input   1      synchronous load strobe
load_gray  input   WIDTH  Gray value to load when load=1
gray_out   output  WIDTH  registered Gray count
bin_out    output  WIDTH  registered binary equivalent of gray_out
step       output  1      one-cycle pulse: gray_out changed by a count step this cycle
wrap       output  1      one-cycle pulse: the step that just occurred wrapped around

Behaviour:
- Reset (async, rst_n=0): gray_out=0, bin_out=0, step=0, wrap=0, prescaler=0. Release is taken synchronously at the next clk edge; the first step needs DIV enabled cycles after release.
- Internal state: binary count bin (WIDTH bits) and prescaler presc, with range 0..DIV-1 and width $clog2(DIV), minimum 1.
- tick = en && (presc == DIV-1). For DIV=1, tick = en.
- Prescaler, per edge, in priority order:
  - load: presc <= 0.
  - otherwise tick: presc <= 0.
  - otherwise en: presc <= presc+1.
  - otherwise: presc holds (not cleared while en=0).
- Counter, per edge, in priority order:
  - load=1: bin <= gray2bin(load_gray); gray_out <= load_gray; step <= 0; wrap <= 0. Load beats tick in the same cycle; that step is discarded.
  - tick and up_dn=1: bin <= bin+1 (mod 2^WIDTH). wrap <= 1 if old bin was all ones.
  - tick and up_dn=0: bin <= bin-1 (mod 2^WIDTH). wrap <= 1 if old bin was 0.
  - On any tick: step <= 1 and gray_out <= bin2gray(new bin).
  - No load and no tick: bin and gray_out hold; step <= 0; wrap <= 0.
- Conversions:
  - bin2gray(b) = b ^ (b>>1).
  - gray2bin: g[WIDTH-1] passes through; b[i] = b[i+1] ^ g[i] for i descending.
- bin_out always equals gray2bin(gray_out), and both update on the same edge (zero relative latency).
- Latency: a step becomes visible on gray_out, bin_out and step in the same cycle, one clk after the edge at which tick was true.
- Gray property: consecutive values produced by steps differ in exactly one bit, including across wrap in both directions. Loads carry no such guarantee.
- Direction change: takes effect at the next tick; presc is unaffected.
- en low: everything holds; step=0 and wrap=0. load still works.
- Async reset mid-operation: all state clears immediately, independent of clk.

Test Plan:
1. WIDTH=4, DIV=2, en=1, up_dn=1 from reset: gray_out advances every 2 cycles through 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. wrap pulses on the 8->0 step; step pulses 16 times in 32 cycles; each transition differs in one bit.
2. WIDTH=4, DIV=2, up_dn=0 from reset: the first step gives gray_out=8, bin_out=F with wrap=1. Next steps give gray_out=9 then B, with wrap=0.
3. DIV=3: hold en=1 for 2 cycles, drop en for 5 cycles, then raise en. The step occurs after 1 further enabled cycle, because presc was held at 2. step=0 throughout the idle period.
4. load with load_gray=4'hE (bin B) asserted in the same cycle as a tick: next cycle gray_out=E, bin_out=B, step=0. The following ticks with up counting give gray_out=A, B, with bin 0xC, 0xD.
5. WIDTH=8, DIV=1: run 300 cycles up, then 300 down. Check gray_out == bin_out ^ (bin_out>>1) every cycle, exactly one wrap per 256 steps, and a final count equal to the start value.
6. Assert rst_n=0 asynchronously between clock edges at count gray=6: outputs go to 0 before the next edge. After release, the first step arrives after exactly DIV enabled cycles.
